// File: rtl/xpb_lut_loadable.sv
// xpb_lut_loadable
// ----------------------------------------------------------------------------
// Runtime-loadable XPB constant tables for the modular squaring datapath.
// NUM_TABLES tables of 2^IDX_W entries, each DATA_W wide. Entry 0 of every
// table is a hardwired zero and has no storage. Host software streams each
// table in over a LOAD_W-wide port. The squarer reads one entry per cycle
// through a fixed two-stage lookup pipeline.
//
// Ports
//   clk, rst        single clock, asynchronous active-high reset
//   load_start      one-cycle pulse: begin loading table load_table
//   load_table      table to load, sampled with load_start
//   load_valid      load word present on load_data
//   load_data       load word (first word of an entry lands in the LSBs)
//   load_ready      a word is accepted this cycle when load_valid is high
//   load_busy       a load is in progress (LOAD and COMMIT)
//   table_ready     per-table "contents valid" flags
//   rd_valid        lookup request
//   rd_table        table selector
//   rd_idx          entry index
//   rd_data         looked-up entry, two cycles after the request
//   rd_data_valid   rd_data answers the request made two cycles earlier
//   rd_err          request hit an unready or out-of-range table (rd_data=0)
// ----------------------------------------------------------------------------
module xpb_lut_loadable #(
    parameter int DATA_W     = 1024,
    parameter int IDX_W      = 5,
    parameter int NUM_TABLES = 4,
    parameter int LOAD_W     = 64,
    parameter int TBL_W      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_start,
    input  logic [TBL_W-1:0]      load_table,
    input  logic                  load_valid,
    input  logic [LOAD_W-1:0]     load_data,
    output logic                  load_ready,
    output logic                  load_busy,
    output logic [NUM_TABLES-1:0] table_ready,
    input  logic                  rd_valid,
    input  logic [TBL_W-1:0]      rd_table,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_data_valid,
    output logic                  rd_err
);

    localparam int DEPTH  = 1 << IDX_W;
    localparam int STORED = DEPTH - 1;               // entry 0 is not stored
    localparam int WPE    = DATA_W / LOAD_W;         // load words per entry
    localparam int WCW    = (WPE > 1) ? $clog2(WPE) : 1;
    localparam int AW     = (NUM_TABLES * STORED > 1) ? $clog2(NUM_TABLES * STORED) : 1;

    generate
        if (DATA_W % LOAD_W != 0) begin : g_bad_load_w
            $error("xpb_lut_loadable: DATA_W must be a multiple of LOAD_W");
        end
        if (TBL_W < 1 || (1 << TBL_W) < NUM_TABLES) begin : g_bad_tbl_w
            $error("xpb_lut_loadable: TBL_W too small for NUM_TABLES");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_COMMIT
    } state_t;

    // Tables are packed back to back; entry i (i >= 1) of table t lives at
    // t*STORED + i - 1.
    function automatic logic [AW-1:0] addr_of(input logic [TBL_W-1:0] t,
                                              input logic [IDX_W-1:0] i);
        return AW'(int'(t) * STORED + int'(i) - 1);
    endfunction

    function automatic logic tbl_ok(input logic [TBL_W-1:0] t);
        return int'(t) < NUM_TABLES;
    endfunction

    // ------------------------------------------------------------------
    // Load side
    // ------------------------------------------------------------------
    state_t                state_q;
    logic [TBL_W-1:0]      ld_tbl_q;
    logic [WCW-1:0]        word_q;
    logic [IDX_W-1:0]      entry_q;     // entries completed so far; target is entry_q+1
    logic                  load_ready_q;
    logic                  load_busy_q;
    logic [NUM_TABLES-1:0] table_ready_q;
    logic [DATA_W-1:0]     asm_q;
    logic [DATA_W-1:0]     asm_d;
    logic [DATA_W-1:0]     mem [NUM_TABLES*STORED];

    logic accept;
    logic last_word;
    logic last_entry;

    // load_ready_q is only ever high in S_LOAD, so it qualifies the handshake.
    assign accept     = load_valid & load_ready_q;
    assign last_word  = (word_q == WCW'(WPE - 1));
    assign last_entry = (entry_q == IDX_W'(DEPTH - 2));

    // Words shift in from the top so that, after WPE words, the first word
    // sits in the LSBs and later words in ascending positions.
    always_comb begin
        asm_d = asm_q >> LOAD_W;
        asm_d[DATA_W-1 -: LOAD_W] = load_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            ld_tbl_q      <= '0;
            word_q        <= '0;
            entry_q       <= '0;
            load_ready_q  <= 1'b0;
            load_busy_q   <= 1'b0;
            table_ready_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (load_start && tbl_ok(load_table)) begin
                        ld_tbl_q                  <= load_table;
                        table_ready_q[load_table] <= 1'b0;
                        word_q                    <= '0;
                        entry_q                   <= '0;
                        load_ready_q              <= 1'b1;
                        load_busy_q               <= 1'b1;
                        state_q                   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        if (last_word) begin
                            word_q <= '0;
                            if (last_entry) begin
                                load_ready_q <= 1'b0;
                                state_q      <= S_COMMIT;
                            end else begin
                                entry_q <= entry_q + 1'b1;
                            end
                        end else begin
                            word_q <= word_q + 1'b1;
                        end
                    end
                end
                S_COMMIT: begin
                    table_ready_q[ld_tbl_q] <= 1'b1;
                    load_busy_q             <= 1'b0;
                    state_q                 <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Assembly buffer and table storage carry no reset; a table's contents
    // are only visible once its ready flag is set by a completed load.
    always_ff @(posedge clk) begin
        if (accept) begin
            asm_q <= asm_d;
            if (last_word) begin
                mem[addr_of(ld_tbl_q, entry_q + 1'b1)] <= asm_d;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read stage 1: capture request, evaluate table readiness
    // ------------------------------------------------------------------
    logic             vld_p1_q;
    logic             rdy_p1_q;
    logic [TBL_W-1:0] tbl_p1_q;
    logic [IDX_W-1:0] idx_p1_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1_q <= 1'b0;
            rdy_p1_q <= 1'b0;
        end else begin
            vld_p1_q <= rd_valid;
            rdy_p1_q <= tbl_ok(rd_table) && table_ready_q[rd_table];
        end
    end

    always_ff @(posedge clk) begin
        tbl_p1_q <= rd_table;
        idx_p1_q <= rd_idx;
    end

    // ------------------------------------------------------------------
    // Read stage 2: fetch entry, register result
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_vld_q;
    logic              rd_err_q;

    always_comb begin
        rd_word = '0;
        if (idx_p1_q != '0) begin
            rd_word = mem[addr_of(tbl_p1_q, idx_p1_q)];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
            rd_vld_q  <= 1'b0;
            rd_err_q  <= 1'b0;
        end else begin
            rd_vld_q <= vld_p1_q;
            rd_err_q <= vld_p1_q && !rdy_p1_q;
            if (vld_p1_q) begin
                rd_data_q <= rdy_p1_q ? rd_word : '0;
            end
        end
    end

    assign load_ready    = load_ready_q;
    assign load_busy     = load_busy_q;
    assign table_ready   = table_ready_q;
    assign rd_data       = rd_data_q;
    assign rd_data_valid = rd_vld_q;
    assign rd_err        = rd_err_q;

endmodule

// File: tb/tb_xpb_lut_loadable.sv
// Testbench for xpb_lut_loadable: directed loads and lookups, checked every
// cycle against a behavioural model of table contents and readiness, plus
// hand-computed literal values.
module tb_xpb_lut_loadable;

    localparam int DATA_W = 1024;
    localparam int IDX_W  = 5;
    localparam int NT     = 4;
    localparam int LOAD_W = 64;
    localparam int TBL_W  = 2;
    localparam int WPE    = DATA_W / LOAD_W;
    localparam int MAXC   = 16384;
    localparam int INF    = 32'h7fffffff;

    logic              clk = 1'b0;
    logic              rst;
    logic              load_start;
    logic [TBL_W-1:0]  load_table;
    logic              load_valid;
    logic [LOAD_W-1:0] load_data;
    logic              load_ready;
    logic              load_busy;
    logic [NT-1:0]     table_ready;
    logic              rd_valid;
    logic [TBL_W-1:0]  rd_table;
    logic [IDX_W-1:0]  rd_idx;
    logic [DATA_W-1:0] rd_data;
    logic              rd_data_valid;
    logic              rd_err;

    xpb_lut_loadable #(
        .DATA_W(DATA_W), .IDX_W(IDX_W), .NUM_TABLES(NT), .LOAD_W(LOAD_W), .TBL_W(TBL_W)
    ) dut (
        .clk(clk), .rst(rst),
        .load_start(load_start), .load_table(load_table), .load_valid(load_valid),
        .load_data(load_data), .load_ready(load_ready), .load_busy(load_busy),
        .table_ready(table_ready),
        .rd_valid(rd_valid), .rd_table(rd_table), .rd_idx(rd_idx),
        .rd_data(rd_data), .rd_data_valid(rd_data_valid), .rd_err(rd_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input bit ok, input string name,
                       input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- model ----------------
    int          rdy_from [NT];   // first sampling edge at which table reads as ready
    logic [15:0] model_tag[NT];   // pattern tag of the table's current contents

    function automatic logic [63:0] word_val(input logic [15:0] tag, input int k, input int w);
        logic [15:0] kk;
        logic [15:0] ww;
        kk = 16'(k);
        ww = 16'(w);
        return {kk, ww, kk, ww} ^ {4{tag}};
    endfunction

    function automatic logic [DATA_W-1:0] entry_val(input logic [15:0] tag, input int k);
        logic [DATA_W-1:0] e;
        e = '0;
        if (k != 0) begin
            for (int w = 0; w < WPE; w++) e[w*LOAD_W +: LOAD_W] = word_val(tag, k, w);
        end
        return e;
    endfunction

    function automatic bit model_ready(input int t, input int n);
        return (t < NT) && (rdy_from[t] <= n);
    endfunction

    function automatic logic [NT-1:0] model_mask();
        logic [NT-1:0] m;
        for (int t = 0; t < NT; t++) m[t] = (rdy_from[t] != INF);
        return m;
    endfunction

    bit              exp_vld [MAXC];
    bit              exp_err [MAXC];
    bit [DATA_W-1:0] exp_data[MAXC];
    bit              hist_vld[MAXC];
    bit              hist_err[MAXC];
    logic [63:0]     hist_lo [MAXC];
    logic [63:0]     hist_hi [MAXC];
    bit              chk_en = 1'b0;
    bit              last_sent = 1'b0;

    // Drive one lookup; it is sampled at edge cyc+1 and its result is visible
    // after edge cyc+2.
    task automatic rd_drive(input int t, input int idx, output int n);
        n        = cyc + 1;
        rd_valid = 1'b1;
        rd_table = TBL_W'(t);
        rd_idx   = IDX_W'(idx);
        if (n < MAXC) begin
            exp_vld[n]  = 1'b1;
            exp_err[n]  = !model_ready(t, n);
            exp_data[n] = model_ready(t, n) ? entry_val(model_tag[t], idx) : '0;
        end
    endtask

    // Per-cycle compare of the read port against the model.
    logic [DATA_W-1:0] hold = '0;
    always @(negedge clk) begin
        int m;
        int n;
        bit ev;
        bit ee;
        logic [DATA_W-1:0] ed;
        m = cyc;
        n = m - 1;
        if (m < MAXC) begin
            hist_vld[m] = rd_data_valid;
            hist_err[m] = rd_err;
            hist_lo[m]  = rd_data[63:0];
            hist_hi[m]  = rd_data[DATA_W-1 -: 64];
        end
        if (rst) begin
            hold = '0;
        end else if (chk_en && n >= 0 && n < MAXC) begin
            ev = exp_vld[n];
            ee = ev ? exp_err[n] : 1'b0;
            ed = ev ? exp_data[n] : hold;
            chk((rd_data_valid === ev) && (rd_err === ee) && (rd_data === ed), "rd_pipe",
                {62'b0, rd_data_valid, rd_err, rd_data[63:0]}, {62'b0, ev, ee, ed[63:0]});
            hold = ed;
        end
    end

    // Stream a full table (entries 1..31, WPE words each). Optional random
    // gaps; optional early return after abort_after accepted words.
    task automatic do_load(input int t, input logic [15:0] tag, input bit gaps,
                           input int abort_after, output int s_edge, output int e_edge);
        int k     = 1;
        int w     = 0;
        int sent  = 0;
        int guard = 0;
        bit bad   = 1'b0;
        last_sent = 1'b0;
        e_edge    = 0;
        @(posedge clk); #1;
        load_start   = 1'b1;
        load_table   = TBL_W'(t);
        s_edge       = cyc + 1;
        model_tag[t] = tag;
        rdy_from[t]  = INF;
        @(posedge clk); #1;
        load_start = 1'b0;
        while (k < (1 << IDX_W) && guard < 4000) begin
            guard++;
            if (!load_busy) bad = 1'b1;
            if (gaps && $urandom_range(1, 0) == 0) begin
                load_valid = 1'b0;
            end else begin
                if (!load_ready) bad = 1'b1;
                load_valid = 1'b1;
                load_data  = word_val(tag, k, w);
                sent++;
                e_edge = cyc + 1;
                w++;
                if (w == WPE) begin
                    w = 0;
                    k++;
                end
                if (k == (1 << IDX_W)) last_sent = 1'b1;
            end
            @(posedge clk); #1;
            if (abort_after > 0 && sent == abort_after) break;
        end
        load_valid = 1'b0;
        last_sent  = 1'b1;
        if (abort_after > 0) begin
            chk(sent == abort_after && !bad, "abort_words", sent, abort_after);
            return;
        end
        chk(!bad && k == (1 << IDX_W), "load_handshake", {bad, 32'(k)}, {1'b0, 32'(1 << IDX_W)});
        // Now in the cycle after the last accepted word: COMMIT.
        chk(load_ready == 1'b0 && load_busy == 1'b1 && table_ready[t] == 1'b0, "commit_state",
            {load_ready, load_busy, table_ready[t]}, 3'b010);
        rdy_from[t] = e_edge + 2;
        @(posedge clk); #1;
        chk(load_ready == 1'b0 && load_busy == 1'b0 && table_ready == model_mask(), "load_done",
            {load_ready, load_busy, table_ready}, {2'b00, model_mask()});
    endtask

    task automatic read_all(input int t, output int n0);
        int nn;
        n0 = 0;
        @(posedge clk); #1;
        for (int i = 0; i < (1 << IDX_W); i++) begin
            rd_drive(t, i, nn);
            if (i == 0) n0 = nn;
            @(posedge clk); #1;
        end
        rd_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, s, e, e2, n0, cnt;
        rst = 1'b1;
        load_start = 1'b0; load_table = '0; load_valid = 1'b0; load_data = '0;
        rd_valid = 1'b0; rd_table = '0; rd_idx = '0;
        for (int t = 0; t < NT; t++) begin
            rdy_from[t]  = INF;
            model_tag[t] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk({load_ready, load_busy, table_ready} == '0, "reset_ctrl",
            {load_ready, load_busy, table_ready}, 0);
        chk({rd_data_valid, rd_err} == 2'b00, "reset_rd_flags", {rd_data_valid, rd_err}, 0);
        chk(rd_data == '0, "reset_rd_data", rd_data[127:0], 0);
        rst    = 1'b0;
        chk_en = 1'b1;

        // Read of an unloaded table.
        @(posedge clk); #1;
        rd_drive(0, 3, n);
        @(posedge clk); #1;
        rd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk(hist_vld[n+1] && hist_err[n+1], "t0_unready_err", {hist_vld[n+1], hist_err[n+1]}, 2'b11);
        chk(hist_lo[n+1] == 64'h0, "t0_unready_data", hist_lo[n+1], 0);

        // Gapless load of table 1.
        do_load(1, 16'h0000, 1'b0, 0, s, e);
        chk(e - s == 496, "load_nogap_len", e - s, 496);
        chk(table_ready == 4'b0010, "tr_after_t1", table_ready, 4'b0010);

        @(posedge clk); #1;
        rd_drive(1, 5, n);
        @(posedge clk); #1;
        rd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk(hist_lo[n+1] == 64'h0005_0000_0005_0000, "t1_idx5_lo", hist_lo[n+1], 64'h0005_0000_0005_0000);
        chk(hist_hi[n+1] == 64'h0005_000F_0005_000F, "t1_idx5_hi", hist_hi[n+1], 64'h0005_000F_0005_000F);
        chk(hist_vld[n+1] && !hist_err[n+1], "t1_idx5_flags", {hist_vld[n+1], hist_err[n+1]}, 2'b10);

        // Reload table 1 with random gaps, then back-to-back reads.
        do_load(1, 16'h0000, 1'b1, 0, s, e);
        read_all(1, n0);
        cnt = 0;
        for (int i = 0; i < 32; i++) if (hist_vld[n0+1+i]) cnt++;
        chk(cnt == 32 && !hist_vld[n0+33], "b2b_count", {hist_vld[n0+33], 32'(cnt)}, 32);
        chk(hist_lo[n0+1] == 64'h0 && hist_hi[n0+1] == 64'h0, "b2b_idx0", hist_lo[n0+1], 0);
        chk(hist_lo[n0+32] == 64'h001F_0000_001F_0000, "b2b_idx31", hist_lo[n0+32], 64'h001F_0000_001F_0000);

        // Load table 2 while reading table 1; read table 2 across its COMMIT.
        fork
            begin
                do_load(2, 16'hA5A5, 1'b1, 0, s, e2);
            end
            begin
                int cnt2;
                int nn;
                cnt2 = 0;
                while (cnt2 < 5) begin
                    @(posedge clk); #1;
                    if (last_sent) begin
                        rd_drive(2, 1 + cnt2, nn);
                        cnt2++;
                    end else begin
                        rd_drive(1, int'($urandom_range(31, 0)), nn);
                    end
                end
                @(posedge clk); #1;
                rd_valid = 1'b0;
            end
        join
        repeat (4) @(posedge clk);
        #1;
        chk(hist_vld[e2+2] && hist_err[e2+2], "commit_cycle_read", {hist_vld[e2+2], hist_err[e2+2]}, 2'b11);
        chk(hist_vld[e2+3] && !hist_err[e2+3], "post_commit_read", {hist_vld[e2+3], hist_err[e2+3]}, 2'b10);
        chk(table_ready == 4'b0110, "tr_after_t2", table_ready, 4'b0110);

        @(posedge clk); #1;
        rd_drive(2, 7, n);
        @(posedge clk); #1;
        rd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk(hist_lo[n+1] == 64'hA5A2_A5A5_A5A2_A5A5, "t2_idx7_lo", hist_lo[n+1], 64'hA5A2_A5A5_A5A2_A5A5);

        // Reset in the middle of a load of table 1.
        do_load(1, 16'h7777, 1'b0, 100, s, e);
        rst = 1'b1;
        #2;
        chk({load_ready, load_busy, table_ready} == '0, "rst_midload_ctrl",
            {load_ready, load_busy, table_ready}, 0);
        chk({rd_data_valid, rd_err} == 2'b00, "rst_midload_rd", {rd_data_valid, rd_err}, 0);
        for (int t = 0; t < NT; t++) rdy_from[t] = INF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;

        @(posedge clk); #1;
        rd_drive(2, 3, n);
        @(posedge clk); #1;
        rd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk(hist_vld[n+1] && hist_err[n+1] && hist_lo[n+1] == 64'h0, "t2_after_rst_err",
            {hist_vld[n+1], hist_err[n+1], hist_lo[n+1]}, {2'b11, 64'h0});

        do_load(1, 16'h0000, 1'b0, 0, s, e);
        chk(table_ready == 4'b0010, "tr_after_reload", table_ready, 4'b0010);
        read_all(1, n0);
        chk(hist_lo[n0+6] == 64'h0005_0000_0005_0000 && !hist_err[n0+6], "reload_idx5",
            {hist_err[n0+6], hist_lo[n0+6]}, {1'b0, 64'h0005_0000_0005_0000});

        repeat (4) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
